// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arb_pkg: state and response-owner encodings for mem_arbiter.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mem_arb_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_BUSY_IF = 3'd1;
  localparam logic [2:0] S_BUSY_DM = 3'd2;
  localparam logic [2:0] S_DROP_IF = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_arb_perf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arb_perf: saturating stall-cycle counters for the IF/DM ports.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_arb_perf (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        if_req,
  input  logic        if_ready,
  input  logic        dm_req,
  input  logic        dm_ready,
  output logic [31:0] if_wait_cnt,
  output logic [31:0] dm_wait_cnt
);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      if_wait_cnt <= '0;
      dm_wait_cnt <= '0;
    end else begin
      if (if_req && !if_ready && (if_wait_cnt != 32'hFFFF_FFFF))
        if_wait_cnt <= if_wait_cnt + 32'd1;
      if (dm_req && !dm_ready && (dm_wait_cnt != 32'hFFFF_FFFF))
        dm_wait_cnt <= dm_wait_cnt + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arbiter: shares one memory port between IF and DM, alternating   |
// | on contention. Optional MEM_ARB_PERF_EN adds wait-cycle counters.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_kill,
  output logic          if_ready,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ready,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]   if_wait_cnt,
  output logic [31:0]   dm_wait_cnt
`endif
);

  logic [2:0] r_state;
  logic       r_last_dm;
  logic       w_if_ok;
  logic       w_grant_dm;
  logic       w_grant_if;
  logic       w_own;

  // On contention the side that did not win last time gets the port.
  assign w_if_ok    = if_req && !if_kill;
  assign w_grant_dm = dm_req && !(w_if_ok && r_last_dm);
  assign w_grant_if = w_if_ok && !w_grant_dm;
  assign w_own      = (r_state == S_BUSY_DM) ? OWN_DM : OWN_IF;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state   <= S_IDLE;
      r_last_dm <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ready  <= 1'b0;
      if_rdata  <= '0;
      dm_ready  <= 1'b0;
      dm_rdata  <= '0;
    end else begin
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_dm) begin
            r_state   <= S_BUSY_DM;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            r_last_dm <= 1'b1;
          end else if (w_grant_if) begin
            r_state   <= S_BUSY_IF;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            r_last_dm <= 1'b0;
          end
        end
        S_BUSY_IF, S_BUSY_DM: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (w_own == OWN_DM) begin
              dm_ready <= 1'b1;
              if (!mem_we)
                dm_rdata <= mem_rdata;
              r_state <= S_RESP;
            end else if (if_kill) begin
              // Kill coinciding with the ack: the registered ready pulse
              // would land in RESP, so the fetch is dropped here instead.
              r_state <= S_IDLE;
            end else begin
              if_rdata <= mem_rdata;
              if_ready <= 1'b1;
              r_state  <= S_RESP;
            end
          end else if ((w_own == OWN_IF) && if_kill) begin
            r_state <= S_DROP_IF;
          end
        end
        S_DROP_IF: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_PERF_EN
  mem_arb_perf u_perf (
    .Clk         (Clk),
    .Rst         (Rst),
    .if_req      (if_req),
    .if_ready    (if_ready),
    .dm_req      (dm_req),
    .dm_ready    (dm_ready),
    .if_wait_cnt (if_wait_cnt),
    .dm_wait_cnt (dm_wait_cnt)
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_arbiter: directed self-checking bench for mem_arbiter.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mem_arbiter;

  logic        Clk;
  logic        Rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_kill;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ready;
  logic [31:0] dm_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] if_wait_cnt;
  logic [31:0] dm_wait_cnt;
`endif

  int n_pass;
  int n_total;

  mem_arbiter #(.AW(32), .DW(32)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_kill   (if_kill),
    .if_ready  (if_ready),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_ready  (dm_ready),
    .dm_rdata  (dm_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
`ifdef MEM_ARB_PERF_EN
    ,
    .if_wait_cnt (if_wait_cnt),
    .dm_wait_cnt (dm_wait_cnt)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic step();
    @(negedge Clk);
  endtask

  task automatic do_ack(input logic [31:0] data);
    mem_rdata = data;
    mem_ack   = 1'b1;
    step();
    mem_ack   = 1'b0;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    Rst = 1'b0; if_req = 1'b1; if_addr = 32'h0; if_kill = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;

    // Reset held with a pending fetch
    step();
    check("rst_mem_req",  mem_req,  0);
    check("rst_if_ready", if_ready, 0);
    check("rst_dm_ready", dm_ready, 0);
    check("rst_mem_addr", mem_addr, 0);
    Rst = 1'b1;
    step();
    check("post_rst_req",  mem_req,  1);
    check("post_rst_addr", mem_addr, 32'h0);
    do_ack(32'h0000_0001);
    check("post_rst_ready", if_ready, 1);
    if_req = 1'b0;
    step();
    check("post_rst_ready_off", if_ready, 0);

    // IF read, memory acks after 2 cycles
    if_req = 1'b1; if_addr = 32'h0000_0004;
    step();
    check("ifrd_req",  mem_req,  1);
    check("ifrd_addr", mem_addr, 32'h0000_0004);
    check("ifrd_we",   mem_we,   0);
    step();
    check("ifrd_hold_req", mem_req, 1);
    check("ifrd_hold_we",  mem_we,  0);
    check("ifrd_no_ready", if_ready, 0);
    do_ack(32'h2008_0005);
    check("ifrd_ready", if_ready, 1);
    check("ifrd_rdata", if_rdata, 32'h2008_0005);
    check("ifrd_req_drop", mem_req, 0);
    if_req = 1'b0;
    step();
    check("ifrd_pulse_1cyc", if_ready, 0);
    check("ifrd_rdata_hold", if_rdata, 32'h2008_0005);

    // Contention with last_dm=0: DM first, then IF
    if_req = 1'b1; if_addr = 32'h0000_0008;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0010;
    step();
    check("cont_dm_addr", mem_addr, 32'h0000_0010);
    check("cont_dm_we",   mem_we,   0);
    do_ack(32'hCAFE_0001);
    check("cont_dm_ready", dm_ready, 1);
    check("cont_dm_rdata", dm_rdata, 32'hCAFE_0001);
    check("cont_if_quiet", if_ready, 0);
    dm_addr = 32'h0000_0014;
    step();
    check("cont_dm_pulse_1cyc", dm_ready, 0);
    step();
    check("cont_if_wins_addr", mem_addr, 32'h0000_0008);
    check("cont_if_wins_we",   mem_we,   0);
    do_ack(32'h1111_2222);
    check("cont_if_ready", if_ready, 1);
    check("cont_if_rdata", if_rdata, 32'h1111_2222);
    check("cont_dm_waits", dm_ready, 0);
    if_req = 1'b0;
    step();
    step();
    check("cont_dm2_addr", mem_addr, 32'h0000_0014);
    do_ack(32'h3333_4444);
    check("cont_dm2_rdata", dm_rdata, 32'h3333_4444);
    dm_req = 1'b0;
    step();

    // DM write: fields stable until ack, dm_rdata untouched
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0020; dm_wdata = 32'hDEAD_BEEF;
    step();
    check("wr_we",    mem_we,    1);
    check("wr_addr",  mem_addr,  32'h0000_0020);
    check("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
    step();
    check("wr_hold_req",   mem_req,   1);
    check("wr_hold_wdata", mem_wdata, 32'hDEAD_BEEF);
    do_ack(32'h5555_5555);
    check("wr_ready", dm_ready, 1);
    check("wr_rdata_kept", dm_rdata, 32'h3333_4444);
    dm_req = 1'b0; dm_we = 1'b0;
    step();

    // Kill during BUSY_IF, ack 3 cycles later
    if_req = 1'b1; if_addr = 32'h0000_0030;
    step();
    check("kill_grant", mem_addr, 32'h0000_0030);
    if_kill = 1'b1;
    step();
    if_kill = 1'b0; if_addr = 32'h0000_0040;
    check("kill_req_held1", mem_req, 1);
    step();
    check("kill_req_held2", mem_req, 1);
    check("kill_addr_held", mem_addr, 32'h0000_0030);
    do_ack(32'h9999_9999);
    check("kill_no_ready", if_ready, 0);
    check("kill_req_drop", mem_req, 0);
    check("kill_rdata_kept", if_rdata, 32'h1111_2222);
    step();
    check("kill_next_addr", mem_addr, 32'h0000_0040);
    check("kill_next_req",  mem_req,  1);
    do_ack(32'h7777_7777);
    check("kill_next_ready", if_ready, 1);
    check("kill_next_rdata", if_rdata, 32'h7777_7777);
    if_req = 1'b0;
    step();

    // if_kill in IDLE suppresses the grant for that cycle
    if_req = 1'b1; if_kill = 1'b1; if_addr = 32'h0000_0080;
    step();
    check("idle_kill_no_grant", mem_req, 0);
    if_kill = 1'b0;
    step();
    check("idle_kill_then_grant", mem_addr, 32'h0000_0080);
    do_ack(32'h0000_0080);
    if_req = 1'b0;
    step();

    // Reset mid-access abandons the DM transaction
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0050;
    step();
    check("mid_grant", mem_req, 1);
    #2 Rst = 1'b0;
    #1 check("mid_async_drop", mem_req, 0);
    step();
    check("mid_no_dm_ready", dm_ready, 0);
    check("mid_dm_rdata_rst", dm_rdata, 32'h0);
    Rst = 1'b1;
    if_req = 1'b1; if_addr = 32'h0000_0070;
    dm_req = 1'b1; dm_addr = 32'h0000_0060;
    step();
    check("mid_last_dm_cleared", mem_addr, 32'h0000_0060);
    do_ack(32'h6060_6060);
    check("mid_dm_ready", dm_ready, 1);
    dm_req = 1'b0;
    step();
    step();
    check("mid_if_after", mem_addr, 32'h0000_0070);
    do_ack(32'h7070_7070);
    check("mid_if_ready", if_ready, 1);
    if_req = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates one shared single-port unified memory between the instruction-fetch (IF) and data-memory (DM) stages of the pipelined MIPS core.
- Sequences one memory transaction at a time over a req/ack handshake and returns a one-cycle ready pulse to the winning requester. The pipeline derives its stalls from the absence of that pulse.
- Sits between the IF/MEM stages and the memory model inside Top.

Parameters:
- AW, 32, address width in bits (byte address, passed through unchanged).
- DW, 32, data width in bits.

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  asynchronous reset, active-low.
- if_req  in  1  IF read request. Must be held until if_ready or if_kill.
- if_addr  in  AW  fetch address.
- if_kill  in  1  branch redirect. Cancels the current or pending fetch.
- if_ready  out  1  one-cycle pulse: if_rdata is valid.
- if_rdata  out  DW  fetched instruction.
- dm_req  in  1  DM request. Must be held until dm_ready.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  AW  data address.
- dm_wdata  in  DW  store data.
- dm_ready  out  1  one-cycle pulse: access done; dm_rdata valid for reads.
- dm_rdata  out  DW  load data.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_ack  in  1  memory completion. Transfer occurs when mem_req and mem_ack are both high.
- mem_rdata  in  DW  memory read data, valid when mem_ack is high.

Behaviour:
- Reset (Rst=0, asynchronous): state=IDLE, last_dm=0. All outputs are 0: mem_req, mem_we, mem_addr, mem_wdata, if_ready, if_rdata, dm_ready, dm_rdata.
- All outputs are registered.
- States: IDLE, BUSY_IF, BUSY_DM, DROP_IF, RESP.
- IDLE grant rules:
  - dm_req only → BUSY_DM.
  - if_req and not if_kill only → BUSY_IF.
  - Both pending → DM wins unless last_dm=1, in which case IF wins. This guarantees alternation and prevents starvation.
  - On grant: load mem_addr/mem_we/mem_wdata from the winner, set mem_req=1, update last_dm (1 for DM, 0 for IF).
  - IF grants always drive mem_we=0.
- BUSY_x: mem_req and all mem_* fields are held stable until mem_ack.
  - On mem_ack: drop mem_req, capture mem_rdata into the winner's rdata register, go to RESP.
  - In RESP, the matching ready output is 1 for exactly that cycle; then return to IDLE.
- Timing: request seen in IDLE at cycle 0 → mem_req=1 at cycle 1 → earliest mem_ack at cycle 1 → ready=1 at cycle 2 → IDLE at cycle 3, where a new request may be granted. Minimum turnaround is 3 cycles per access.
- Requester rule: after its ready pulse, a requester deasserts req or presents its next request. Request inputs are only sampled in IDLE, so the ready cycle can never double-grant.
- dm_rdata is updated only for DM reads. On DM writes dm_rdata holds its previous value.
- if_kill handling:
  - In BUSY_IF → DROP_IF. mem_req stays asserted until mem_ack (memory transactions are never aborted). On ack, data is discarded, no if_ready pulse, return to IDLE.
  - In IDLE, if_kill suppresses the IF grant that cycle.
  - In RESP for IF, if_kill suppresses the if_ready pulse.
  - In BUSY_DM, if_kill is ignored.
- Rst asserted mid-transaction: immediate return to IDLE. mem_req drops asynchronously and the outstanding access is abandoned. The memory must tolerate mem_req falling without an ack.
- if_rdata and dm_rdata hold their last value between pulses.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- Defined: adds outputs if_wait_cnt[31:0] and dm_wait_cnt[31:0].
  - Each counts cycles in which its req=1 and its ready=0.
  - Counters saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding localparams: S_IDLE=3'd0, S_BUSY_IF=3'd1, S_BUSY_DM=3'd2, S_DROP_IF=3'd3, S_RESP=3'd4;
  - the response-owner encoding (OWN_IF=1'b0, OWN_DM=1'b1).
- One natural sub-module: mem_arb_perf (the saturating counter pair). It is instantiated only under MEM_ARB_PERF_EN.

Test Plan:
- Reset: hold Rst=0 for 10 ns with if_req=1 → mem_req=0, if_ready=0, dm_ready=0. Release → mem_req=1 with mem_addr=if_addr=32'h0000_0000 one cycle later.
- IF read: if_addr=32'h0000_0004, memory acks after 2 cycles with 32'h2008_0005 → if_ready pulses exactly 1 cycle with if_rdata=32'h2008_0005; mem_we=0 throughout.
- Contention: if_req and dm_req (read, addr 32'h0000_0010) both high from IDLE with last_dm=0 → DM granted first, dm_ready pulses. Next grant goes to IF (last_dm=1) even with dm_req re-asserted.
- DM write: dm_we=1, dm_addr=32'h0000_0020, dm_wdata=32'hDEAD_BEEF → mem_we=1 and fields stable until mem_ack; dm_ready pulses; dm_rdata unchanged.
- Kill: if_kill=1 pulse while in BUSY_IF, ack arrives 3 cycles later → mem_req held until ack, no if_ready pulse, back to IDLE; an if_req at a new address is granted next.
- Reset mid-access: drop Rst during BUSY_DM → mem_req=0 immediately, no dm_ready pulse; after release the arbiter is in IDLE with last_dm=0.
